spi_slave_rx: RTL

- SPI slave endpoint: the receiving end of links driven by the team's SPI master FSM.
- Samples MOSI on SCLK rising edges (mode 0, MSB first) and presents each completed word to the system side with a one-cycle valid pulse.
- Shifts a preloaded reply word out on MISO at the same time.
- Runs entirely in the system clock domain. SCLK, CS_N and MOSI are oversampled through synchronizers.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave_rx.sv | 118 +++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave receive path: state encoding, default
// word width, bus mode and a counter-width helper.
package spi_pkg;

  localparam int unsigned SPI_DATA_W = 8;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TRX  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned w;
    w = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v != 0) begin
      w++;
      v = v >> 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI pin, followed by an edge
// register that yields single-cycle rise/fall strobes in the clk domain.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= {STAGES{RESET_VAL}};
      prev <= RESET_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave endpoint: oversamples sclk/cs_n/mosi in the clk domain,
// assembles MSB-first words and shifts a preloaded reply out on miso.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int unsigned       DATA_W      = SPI_DATA_W,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_WORD   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              abort
);

  localparam int unsigned       CNT_W    = (clog2(DATA_W) > 0) ? clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic              sclk_level, sclk_rise, sclk_fall;
  logic              cs_level, cs_rise, cs_fall;
  logic              mosi_level, mosi_rise, mosi_fall;
  logic              sample_edge, shift_edge;
  logic [1:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] reply_buf;
  logic              unused_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = ^{sclk_level, cs_rise, mosi_rise, mosi_fall};

  assign sample_edge = (SPI_CPOL ^ SPI_CPHA) ? sclk_fall : sclk_rise;
  assign shift_edge  = (SPI_CPOL ^ SPI_CPHA) ? sclk_rise : sclk_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      reply_buf <= IDLE_WORD;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      abort     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      abort    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_load) reply_buf <= tx_data;
          if (cs_fall) begin
            tx_shift <= reply_buf;
            bit_cnt  <= '0;
            state    <= ST_TRX;
          end
        end
        ST_TRX: begin
          if (sample_edge) begin
            rx_shift <= {rx_shift[DATA_W-2:0], mosi_level};
            bit_cnt  <= bit_cnt + 1'b1;
          end
          // The trailing fall of the previous word lands at count 0; skipping
          // it keeps a freshly loaded back-to-back reply word intact.
          if (shift_edge && (bit_cnt != '0)) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          if (sample_edge && (bit_cnt == LAST_BIT)) begin
            state <= ST_DONE;
          end else if (cs_level) begin
            abort    <= (bit_cnt != '0);
            rx_shift <= '0;
            state    <= ST_IDLE;
          end
        end
        ST_DONE: begin
          rx_data   <= rx_shift;
          rx_valid  <= 1'b1;
          reply_buf <= IDLE_WORD;
          bit_cnt   <= '0;
          if (!cs_level) begin
            tx_shift <= IDLE_WORD;
            state    <= ST_TRX;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign miso     = ~cs_level & tx_shift[DATA_W-1];

endmodule
